// File: rtl/pong_vel_sched.sv
// ============================================================================
// pong_vel_sched : serve/rally FSM and dy table producing registered (vx, vy)
// Rev 1.0
// ============================================================================
`default_nettype none

module pong_vel_sched #(
  parameter int SERVE_TICKS    = 60,
  parameter int HITS_PER_LEVEL = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              serve_req,
  input  logic              hit_l,
  input  logic              hit_r,
  input  logic              wall,
  input  logic              miss_l,
  input  logic              miss_r,
  output logic signed [2:0] vx,
  output logic signed [2:0] vy,
  output logic              moving,
  output logic              point_l,
  output logic              point_r
);

  localparam logic [7:0] C_SERVE_TICKS = 8'(SERVE_TICKS);
  localparam logic [3:0] C_HPL         = 4'(HITS_PER_LEVEL);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2
  } state_t;

  state_t             state_q;
  logic [7:0]         tick_cnt_q;
  logic [2:0]         idx_q;
  logic [1:0]         speed_q;
  logic [3:0]         hit_cnt_q;
  logic               serve_dir_q;
  logic signed [2:0]  vx_q;
  logic signed [2:0]  vy_q;
  logic               moving_q;
  logic               point_l_q;
  logic               point_r_q;

  logic signed [2:0]  w_rom_dy;
  logic [2:0]         idx_d;
  logic [3:0]         w_hit_inc;
  logic [3:0]         hit_cnt_d;
  logic [1:0]         speed_d;
  logic [7:0]         tick_cnt_d;
  logic               w_serve_done;
  logic signed [2:0]  w_serve_vx;
  logic signed [2:0]  w_hit_spd;
  logic               w_hit_l_ok;
  logic               w_hit_r_ok;

  always_comb begin
    case (idx_q)
      3'd0:    w_rom_dy = 3'sb111;
      3'd1:    w_rom_dy = 3'sb110;
      3'd2:    w_rom_dy = 3'sb101;
      3'd3:    w_rom_dy = 3'sb010;
      3'd4:    w_rom_dy = 3'sb001;
      3'd5:    w_rom_dy = 3'sb010;
      3'd6:    w_rom_dy = 3'sb011;
      default: w_rom_dy = 3'sb000;
    endcase
  end

  // Speed after an accepted hit, so the same-cycle level-up is applied to vx
  always_comb begin
    idx_d     = (idx_q == 3'd6) ? 3'd0 : idx_q + 3'd1;
    w_hit_inc = hit_cnt_q + 4'd1;
    hit_cnt_d = w_hit_inc;
    speed_d   = speed_q;
    if (w_hit_inc == C_HPL) begin
      hit_cnt_d = 4'd0;
      speed_d   = (speed_q == 2'd3) ? 2'd3 : speed_q + 2'd1;
    end
    w_hit_spd    = $signed({1'b0, speed_d});
    w_serve_vx   = serve_dir_q ? -$signed({1'b0, speed_q}) : $signed({1'b0, speed_q});
    tick_cnt_d   = tick_cnt_q + 8'd1;
    w_serve_done = tick && (tick_cnt_d == C_SERVE_TICKS);
    w_hit_l_ok   = hit_l && vx_q[2];
    w_hit_r_ok   = hit_r && !vx_q[2] && (vx_q != 3'sb000);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      tick_cnt_q  <= 8'd0;
      idx_q       <= 3'd0;
      speed_q     <= 2'd1;
      hit_cnt_q   <= 4'd0;
      serve_dir_q <= 1'b0;
      vx_q        <= 3'sb000;
      vy_q        <= 3'sb000;
      moving_q    <= 1'b0;
      point_l_q   <= 1'b0;
      point_r_q   <= 1'b0;
    end else begin
      point_l_q <= 1'b0;
      point_r_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          vx_q     <= 3'sb000;
          vy_q     <= 3'sb000;
          moving_q <= 1'b0;
          if (serve_req) begin
            state_q    <= ST_SERVE;
            tick_cnt_q <= 8'd0;
          end
        end
        ST_SERVE: begin
          vx_q     <= 3'sb000;
          vy_q     <= 3'sb000;
          moving_q <= 1'b0;
          if (tick) tick_cnt_q <= tick_cnt_d;
          if (w_serve_done) begin
            state_q  <= ST_PLAY;
            moving_q <= 1'b1;
            vx_q     <= w_serve_vx;
            vy_q     <= w_rom_dy;
            idx_q    <= idx_d;
          end
        end
        ST_PLAY: begin
          moving_q <= 1'b1;
          if (miss_l || miss_r) begin
            point_r_q   <= miss_l;
            point_l_q   <= !miss_l;
            serve_dir_q <= miss_l;
            speed_q     <= 2'd1;
            hit_cnt_q   <= 4'd0;
            vx_q        <= 3'sb000;
            vy_q        <= 3'sb000;
            moving_q    <= 1'b0;
            tick_cnt_q  <= 8'd0;
            state_q     <= ST_SERVE;
          end else if (w_hit_l_ok || w_hit_r_ok) begin
            vx_q      <= w_hit_l_ok ? w_hit_spd : -w_hit_spd;
            vy_q      <= w_rom_dy;
            idx_q     <= idx_d;
            hit_cnt_q <= hit_cnt_d;
            speed_q   <= speed_d;
          end else if (wall) begin
            vy_q <= -vy_q;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign vx      = vx_q;
  assign vy      = vy_q;
  assign moving  = moving_q;
  assign point_l = point_l_q;
  assign point_r = point_r_q;

endmodule

`default_nettype wire

// File: tb/tb_pong_vel_sched.sv
// ============================================================================
// tb_pong_vel_sched : scoreboard bench with a behavioural velocity model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pong_vel_sched;

  localparam int SERVE_TICKS    = 60;
  localparam int HITS_PER_LEVEL = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick = 1'b0, serve_req = 1'b0;
  logic hit_l = 1'b0, hit_r = 1'b0, wall = 1'b0, miss_l = 1'b0, miss_r = 1'b0;
  logic signed [2:0] vx, vy;
  logic moving, point_l, point_r;

  pong_vel_sched #(.SERVE_TICKS(SERVE_TICKS), .HITS_PER_LEVEL(HITS_PER_LEVEL)) dut (
    .clk(clk), .rst(rst), .tick(tick), .serve_req(serve_req),
    .hit_l(hit_l), .hit_r(hit_r), .wall(wall), .miss_l(miss_l), .miss_r(miss_r),
    .vx(vx), .vy(vy), .moving(moving), .point_l(point_l), .point_r(point_r)
  );

  always #5 clk = ~clk;

  typedef struct {
    int vx;
    int vy;
    bit mv;
    bit pl;
    bit pr;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: game rules as plain integers
  int rom[7] = '{-1, -2, -3, 2, 1, 2, 3};
  string m_mode;
  int m_cnt, m_idx, m_speed, m_hits, m_dir, m_vx, m_vy;
  bit m_pl, m_pr;

  task automatic model_reset();
    m_mode = "IDLE"; m_cnt = 0; m_idx = 0; m_speed = 1; m_hits = 0;
    m_dir = 0; m_vx = 0; m_vy = 0; m_pl = 0; m_pr = 0;
  endtask

  task automatic model_paddle(input int sign);
    m_hits++;
    if (m_hits == HITS_PER_LEVEL) begin
      m_hits  = 0;
      m_speed = (m_speed < 3) ? m_speed + 1 : 3;
    end
    m_vx  = sign * m_speed;
    m_vy  = rom[m_idx];
    m_idx = (m_idx + 1) % 7;
  endtask

  task automatic model_step(input bit r, t, s, hl, hr, w, ml, mr);
    if (!r) begin
      model_reset();
      return;
    end
    m_pl = 0; m_pr = 0;
    if (m_mode == "IDLE") begin
      m_vx = 0; m_vy = 0;
      if (s) begin m_mode = "SERVE"; m_cnt = 0; end
    end else if (m_mode == "SERVE") begin
      m_vx = 0; m_vy = 0;
      if (t) begin
        m_cnt++;
        if (m_cnt == SERVE_TICKS) begin
          m_mode = "PLAY";
          m_vx   = m_dir ? -m_speed : m_speed;
          m_vy   = rom[m_idx];
          m_idx  = (m_idx + 1) % 7;
        end
      end
    end else begin
      if (ml || mr) begin
        m_pr = ml; m_pl = !ml; m_dir = ml ? 1 : 0;
        m_speed = 1; m_hits = 0; m_vx = 0; m_vy = 0;
        m_mode = "SERVE"; m_cnt = 0;
      end else if (hl && m_vx < 0) model_paddle(1);
      else if (hr && m_vx > 0) model_paddle(-1);
      else if (w) m_vy = -m_vy;
    end
  endtask

  task automatic drive(input bit r, t, s, hl, hr, w, ml, mr);
    exp_t e;
    @(negedge clk);
    rst = r; tick = t; serve_req = s;
    hit_l = hl; hit_r = hr; wall = w; miss_l = ml; miss_r = mr;
    model_step(r, t, s, hl, hr, w, ml, mr);
    e.vx = m_vx; e.vy = m_vy; e.mv = (m_mode == "PLAY"); e.pl = m_pl; e.pr = m_pr;
    exp_q.push_back(e);
  endtask

  task automatic idle_cyc(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // n ticks spaced by a quiet cycle; paddle/wall noise on the quiet cycles
  task automatic ticks(input int n, input bit sreq);
    for (int i = 0; i < n; i++) begin
      drive(1, 1, sreq, 0, 0, 0, 0, 0);
      drive(1, 0, sreq, i[0], !i[0], i[1], 0, 0);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (int'(vx) != e.vx || int'(vy) != e.vy || moving !== e.mv ||
          point_l !== e.pl || point_r !== e.pr) begin
        n_bad++;
        $display("FAIL outputs @%0t: got vx=%0d vy=%0d mv=%b pl=%b pr=%b, want vx=%0d vy=%0d mv=%b pl=%b pr=%b",
                 $time, vx, vy, moving, point_l, point_r, e.vx, e.vy, e.mv, e.pl, e.pr);
      end
    end
  end

  initial begin
    model_reset();
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
    idle_cyc(3);
    // first serve and launch to the right
    drive(1, 0, 1, 0, 0, 0, 0, 0);
    ticks(SERVE_TICKS, 0);
    drive(1, 0, 0, 1, 0, 0, 0, 0);
    // alternating hits walk the table past its wrap and up to top speed
    for (int i = 0; i < 14; i++) begin
      drive(1, 0, 0, i[0], !i[0], 0, 0, 0);
      drive(1, i[1], 0, 0, 0, 1, 0, 0);
      drive(1, 0, 0, 0, !i[0] ? 1'b0 : 1'b1, 0, 0, 0);
    end
    drive(1, 1, 0, 1, 1, 1, 1, 0);
    idle_cyc(2);
    ticks(SERVE_TICKS, 1);
    drive(1, 0, 1, 0, 0, 1, 0, 0);
    drive(1, 0, 1, 1, 0, 0, 0, 1);
    // reset in the middle of SERVE, then no restart without serve_req
    ticks(30, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    ticks(SERVE_TICKS + 2, 0);
    drive(1, 0, 1, 0, 0, 0, 0, 0);
    ticks(SERVE_TICKS, 0);
    drive(1, 0, 0, 0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    idle_cyc(4);
    // randomized play
    for (int i = 0; i < 6000; i++) begin
      drive($urandom_range(0, 799) != 0,
            (i % 2 == 0) && ($urandom_range(0, 3) != 0),
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 6) == 0,
            $urandom_range(0, 149) == 0,
            $urandom_range(0, 149) == 0);
    end
    idle_cyc(1);
    repeat (4) @(posedge clk);
    #3;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
